seven_segment_mmio_ctrl: RTL

- Memory-mapped 8-digit hex display controller inside topaz_geyser_core.
- Sits between the CPU data bus and the top-level seven_segment_control_field output, and produces that 15-bit field directly.
- Firmware writes a 32-bit value plus a blank mask; the block time-multiplexes the digits with a refresh counter and inserts dead-time between digits to suppress ghosting.

---
 rtl/seven_segment_mmio_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seven_segment_mmio_ctrl.sv
// seven_segment_mmio_ctrl
//   Memory-mapped 8-digit hex display controller. Firmware writes a 32-bit value (DATA), a
//   per-digit blank mask (BLANK) and an enable (CTRL.en). While enabled, the block scans the
//   digits one at a time: each digit slot lasts REFRESH_DIV cycles, and the first DEADTIME
//   cycles of every slot drive all anodes off so the previous digit does not ghost.
//
// Ports
//   sys_clk                     system clock, rising edge
//   cpu_rst                     asynchronous active-low reset
//   bus_req/bus_we/bus_addr     single-cycle access strobe, direction, byte address
//   bus_wdata/bus_wstrb         write data and byte enables
//   bus_rdata/bus_ack           registered read data and one-cycle acknowledge
//   seven_segment_control_field [14:7] anodes an7..an0, [6:0] segments gfedcba, active-low
//
// Register map (bus_addr[3:2])
//   0x0 DATA[31:0] byte-strobed, 0x4 BLANK[7:0], 0x8 CTRL[0] en, 0xC reads 0.

module seven_segment_mmio_ctrl #(
  parameter int unsigned REFRESH_DIV = 65536,
  parameter int unsigned DEADTIME    = 16
) (
  input  logic        sys_clk,
  input  logic        cpu_rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic [14:0] seven_segment_control_field
);

  localparam int unsigned   CntW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(REFRESH_DIV - 1);
  localparam logic [14:0]   FieldDark = 15'h7FFF;

  localparam logic [1:0] RegData  = 2'd0;
  localparam logic [1:0] RegBlank = 2'd1;
  localparam logic [1:0] RegCtrl  = 2'd2;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [31:0]     data_q, data_d;
  logic [7:0]      blank_q, blank_d;
  logic            en_q, en_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [14:0]     field_q, field_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [1:0]  reg_sel;
  logic        wr_en;
  logic [31:0] rd_val;

  // Byte-lane bits of the address carry no meaning for word registers.
  logic unused_addr;
  assign unused_addr = ^bus_addr[1:0];

  assign reg_sel = bus_addr[3:2];
  assign wr_en   = bus_req & bus_we;

  // Bus side: register writes and read-data capture.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      RegData:  rd_val = data_q;
      RegBlank: rd_val = {24'b0, blank_q};
      RegCtrl:  rd_val = {31'b0, en_q};
      default:  rd_val = '0;
    endcase

    data_d  = data_q;
    blank_d = blank_q;
    en_d    = en_q;
    if (wr_en) begin
      case (reg_sel)
        RegData: begin
          for (int b = 0; b < 4; b++) begin
            if (bus_wstrb[b]) data_d[8*b +: 8] = bus_wdata[8*b +: 8];
          end
        end
        RegBlank: if (bus_wstrb[0]) blank_d = bus_wdata[7:0];
        RegCtrl:  if (bus_wstrb[0]) en_d = bus_wdata[0];
        default: ;
      endcase
    end

    // Read data reflects pre-write state and drops back to 0 with the ack.
    ack_d   = bus_req;
    rdata_d = bus_req ? rd_val : '0;
  end

  // Scan side: the output is computed from the registered counter/index/data, so any
  // register change becomes visible exactly one edge later.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    field_d = FieldDark;
    if (en_q) begin
      if (cnt_q == CntMax) begin
        cnt_d = '0;
        idx_d = idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      if ((32'(cnt_q) >= DEADTIME) && !blank_q[idx_q]) begin
        field_d = {~(8'b1 << idx_q), hex_to_seg(data_q[{idx_q, 2'b00} +: 4])};
      end
    end else begin
      // Disabled: park at the start of digit 0 so re-enable begins with dead-time.
      cnt_d = '0;
      idx_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      data_q  <= '0;
      blank_q <= 8'hFF;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      field_q <= FieldDark;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      blank_q <= blank_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      field_q <= field_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_ack                     = ack_q;
  assign bus_rdata                   = rdata_q;
  assign seven_segment_control_field = field_q;

endmodule
